// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_UU = 2'd0,
    MUL_SS = 2'd1,
    MUL_SU = 2'd2
  } mul_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Iterations needed to retire WIDTH+1 multiplier bits, STEP bits at a time.
  function automatic int mul_iters(input int width, input int step);
    return (width + step) / step;
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Request/result bus of mul_unit; master is the requester/consumer, slave is the unit.
interface mul_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             iValidIn;
  logic             oReady;
  logic [WIDTH-1:0] iMulc;
  logic [WIDTH-1:0] iMulr;
  logic [1:0]       iMode;
  logic [TAG_W-1:0] iTag;
  logic             iFlush;
  logic             oValid;
  logic             iReadyOut;
  logic [WIDTH-1:0] oRsltHi;
  logic [WIDTH-1:0] oRsltLo;
  logic [TAG_W-1:0] oTag;

  modport master (
    output iValidIn, iMulc, iMulr, iMode, iTag, iFlush, iReadyOut,
    input  oReady, oValid, oRsltHi, oRsltLo, oTag
  );

  modport slave (
    input  iValidIn, iMulc, iMulr, iMode, iTag, iFlush, iReadyOut,
    output oReady, oValid, oRsltHi, oRsltLo, oTag
  );

endinterface

// File: rtl/mul_step.sv
// One radix-2^STEP partial product of the shifted multiplicand; when last_i is set
// the top digit bit carries negative weight (two's-complement multiplier MSB).
module mul_step #(
  parameter int PW   = 64,
  parameter int STEP = 2
) (
  input  logic [PW-1:0]   mcand_i,
  input  logic [STEP-1:0] digit_i,
  input  logic            last_i,
  output logic [PW-1:0]   pp_o
);

  // Shift-add over the digit bits; no multiplier inferred.
  always_comb begin
    pp_o = {PW{1'b0}};
    for (int j = 0; j < STEP; j++) begin
      if (digit_i[j]) begin
        if (last_i && (j == STEP - 1)) begin
          pp_o = pp_o - (mcand_i << j);
        end else begin
          pp_o = pp_o + (mcand_i << j);
        end
      end else begin
        pp_o = pp_o;
      end
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative signed/unsigned multiplier: STEP multiplier bits per cycle, zero early-out,
// registered result with valid/ready handoff and back-to-back accept from DONE.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  mul_unit_if.slave   bus
);

  localparam int N     = mul_iters(WIDTH, STEP);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int MW    = N * STEP;

  mul_state_e        state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     rslt_q, rslt_d;
  logic [MW-1:0]     mlr_q, mlr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  otag_q, otag_d;
  logic              zero_q, zero_d;

  logic              ready_s;
  logic              accept_s;
  logic              last_s;
  logic              sgn_a_s;
  logic              sgn_b_s;
  logic [PW-1:0]     pp_s;
  logic [PW-1:0]     sum_s;
  logic signed [WIDTH:0] a_ext_s;
  logic signed [WIDTH:0] b_ext_s;

  // Operand signedness decode; the unused encoding falls back to unsigned.
  always_comb begin
    case (bus.iMode)
      MUL_SS:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      MUL_SU:  begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      MUL_UU:  begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
      default: begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
  end

  assign a_ext_s = {sgn_a_s & bus.iMulc[WIDTH-1], bus.iMulc};
  assign b_ext_s = {sgn_b_s & bus.iMulr[WIDTH-1], bus.iMulr};

  // Ready decode; a flush suppresses any accept in the same cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: ready_s = ~bus.iFlush;
      ST_DONE: ready_s = bus.iReadyOut & ~bus.iFlush;
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.iValidIn & ready_s;
  assign last_s   = (cnt_q == CNT_W'(N - 1));
  assign sum_s    = acc_q + pp_s;

  mul_step #(
    .PW   (PW),
    .STEP (STEP)
  ) u_step (
    .mcand_i (mcand_q),
    .digit_i (mlr_q[STEP-1:0]),
    .last_i  (last_s),
    .pp_o    (pp_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    rslt_d  = rslt_q;
    mlr_d   = mlr_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    otag_d  = otag_q;
    zero_d  = zero_q;

    if (bus.iFlush) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      rslt_d  = {PW{1'b0}};
      otag_d  = {TAG_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (zero_q) begin
            state_d = ST_DONE;
            rslt_d  = {PW{1'b0}};
            otag_d  = tag_q;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            acc_d   = sum_s;
            mcand_d = mcand_q << STEP;
            mlr_d   = mlr_q >> STEP;
            if (last_s) begin
              state_d = ST_DONE;
              rslt_d  = sum_s;
              otag_d  = tag_q;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (accept_s) begin
            state_d = ST_BUSY;
          end else if (bus.iReadyOut) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase

      // Capture overrides the iteration registers whenever a request is taken.
      if (accept_s) begin
        mcand_d = PW'(a_ext_s);
        mlr_d   = MW'(b_ext_s);
        acc_d   = {PW{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        tag_d   = bus.iTag;
        zero_d  = (bus.iMulc == {WIDTH{1'b0}}) || (bus.iMulr == {WIDTH{1'b0}});
      end else begin
        zero_d  = zero_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= {PW{1'b0}};
      acc_q   <= {PW{1'b0}};
      rslt_q  <= {PW{1'b0}};
      mlr_q   <= {MW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      tag_q   <= {TAG_W{1'b0}};
      otag_q  <= {TAG_W{1'b0}};
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      rslt_q  <= rslt_d;
      mlr_q   <= mlr_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.oReady  = ready_s;
  assign bus.oValid  = (state_q == ST_DONE);
  assign bus.oRsltHi = rslt_q[PW-1:WIDTH];
  assign bus.oRsltLo = rslt_q[WIDTH-1:0];
  assign bus.oTag    = otag_q;

endmodule
